// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   NOP_INSTR     : canonical RV32I NOP (addi x0, x0, 0) shown when no entry is valid
//   fetch_entry_t : one fetched {pc, instr} pair held in the fetch buffer
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetch entries between the ROM requester and decode.
//   clk, rst_n : clock and asynchronous active-low reset
//   push_i     : write wdata_i (accepted when not full, or when full and popping)
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : discard all entries; overrides push and pop
//   wdata_i    : entry to write
//   rdata_o    : head entry (undefined contents when empty_o)
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t            mem_q [DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic                    push_en;
    logic                    pop_en;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full buffer can still accept.
    assign pop_en  = pop_i & ~empty_o & ~flush_i;
    assign push_en = push_i & (~full_o | pop_en) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, addresses the combinational instruction ROM,
// buffers {pc, instr} pairs and presents them to decode over valid/ready. Execute redirects
// it on taken branches and jumps.
//   clk, rst_n      : clock and asynchronous active-low reset
//   imem_addr       : ROM word address (fetch PC bits [ADDR_WIDTH+1:2])
//   imem_data       : ROM instruction for imem_addr
//   redirect_valid  : flush the buffer and restart fetching at redirect_pc
//   redirect_pc     : redirect target byte address (bits [1:0] ignored)
//   if_valid        : head entry valid to decode
//   if_ready        : decode accepts the head entry this cycle
//   if_pc, if_instr : head entry; 0 / NOP when the buffer is empty
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_instr
);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         push;
    logic         pop;
    logic         buf_full;
    logic         buf_empty;
    fetch_entry_t buf_wdata;
    fetch_entry_t buf_head;
    logic         unused_redirect_lsb;

    // Targets are word aligned; the byte offset bits are dropped.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Upper PC bits are truncated, so high PCs alias low ROM words.
    assign imem_addr = fetch_pc_q[ADDR_WIDTH+1:2];

    assign pop  = if_valid & if_ready;
    assign push = ~redirect_valid & (~buf_full | pop);

    assign buf_wdata.pc    = fetch_pc_q;
    assign buf_wdata.instr = imem_data;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (buf_wdata),
        .rdata_o (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    always_comb begin
        if_valid = ~buf_empty;
        if_pc    = 32'h0000_0000;
        if_instr = NOP_INSTR;
        if (!buf_empty) begin
            if_pc    = buf_head.pc;
            if_instr = buf_head.instr;
        end
    end

endmodule
